// File: rtl/text_mode_pkg.sv
// Shared types and constants for the text-mode display: cell geometry,
// read-return tags and the host access state machine encoding.
package text_mode_pkg;
    localparam int CELLS  = 2000;
    localparam int ADDR_W = 11;
    localparam int CHR_W  = 8;

    typedef enum logic [1:0] {NONE, DISP, HOST} tag_e;
    typedef enum logic [1:0] {IDLE, WR_PEND, RD_PEND} host_state_e;

    // One cursor step with wrap-around over the visible cell range.
    function automatic logic [ADDR_W-1:0] cursor_step(input logic [ADDR_W-1:0] cur,
                                                      input logic              up);
        if (up) return (cur == ADDR_W'(CELLS - 1)) ? '0 : cur + 1'b1;
        else    return (cur == '0) ? ADDR_W'(CELLS - 1) : cur - 1'b1;
    endfunction
endpackage

// File: rtl/screen_ram_sched_if.sv
// Display-fetch and screen-RAM signals seen by the scheduler; the scheduler
// uses the slave view, the fetch logic plus RAM use the master view.
interface screen_ram_sched_if;
    import text_mode_pkg::*;

    logic              disp_req_i;
    logic [ADDR_W-1:0] disp_addr_i;
    logic              disp_valid_o;
    logic [CHR_W-1:0]  disp_data_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [CHR_W-1:0]  ram_data_o;
    logic              ram_wren_o;
    logic [CHR_W-1:0]  ram_q_i;

    modport master (
        output disp_req_i, disp_addr_i, ram_q_i,
        input  disp_valid_o, disp_data_o, ram_addr_o, ram_data_o, ram_wren_o
    );
    modport slave (
        input  disp_req_i, disp_addr_i, ram_q_i,
        output disp_valid_o, disp_data_o, ram_addr_o, ram_data_o, ram_wren_o
    );
endinterface

// File: rtl/btn_edge_sync.sv
// Purpose: 2-flop synchronizer for a raw button level plus rising-edge pulse.
// Latency: pulse is high in the 2nd cycle after the first sampling edge.
// Backpressure: none; one 1-cycle pulse per rising edge of the raw level.
module btn_edge_sync (
    input  logic clk,
    input  logic rst_i,
    input  logic raw,
    output logic pulse
);
    logic [2:0] sr;

    always_ff @(posedge clk) begin
        if (rst_i) sr <= '0;
        else       sr <= {sr[1:0], raw};
    end

    assign pulse = sr[1] & ~sr[2];
endmodule

// File: rtl/screen_ram_sched.sv
// Purpose: shares the single-port screen RAM between display fetch and host write/readback; owns the cursor.
// Latency: display data valid RAM_LAT cycles after request; host write issue >= 1 cycle after latch.
// Backpressure: display always wins; host accesses wait for a display-idle cycle, stalls flagged sticky.
module screen_ram_sched
    import text_mode_pkg::*;
#(
    parameter int RAM_LAT     = 1,
    parameter int STALL_LIMIT = 255
) (
    input  logic               clk,
    input  logic               rst_i,
    screen_ram_sched_if.slave  bus,
    input  logic               addr_inc_i,
    input  logic               addr_inc_dir_i,
    input  logic               wren_i,
    input  logic [CHR_W-1:0]   data_sw_i,
    output logic [ADDR_W-1:0]  cursor_o,
    output logic [CHR_W-1:0]   cur_data_o,
    output logic               busy_o,
    output logic               stall_err_o
);
    localparam int                CNT_W = $clog2(STALL_LIMIT + 2);
    localparam logic [CNT_W-1:0]  LIM   = CNT_W'(STALL_LIMIT);

    logic              step, wr;
    host_state_e       state, state_nxt;
    logic              rb_flag, rb_flag_nxt;
    logic              latch_wr, issue_wr, issue_rd;
    logic [ADDR_W-1:0] wr_addr;
    logic [CHR_W-1:0]  wr_data;
    logic [CNT_W-1:0]  stall_cnt;
    logic              host_in_flight;
    tag_e              tag_in;
    tag_e              tag_q [RAM_LAT];
    tag_e              tag_out;

    btn_edge_sync u_step_sync (.clk(clk), .rst_i(rst_i), .raw(addr_inc_i), .pulse(step));
    btn_edge_sync u_wr_sync   (.clk(clk), .rst_i(rst_i), .raw(wren_i),     .pulse(wr));

    always_comb begin
        state_nxt   = state;
        rb_flag_nxt = rb_flag;
        latch_wr    = 1'b0;
        issue_wr    = 1'b0;
        issue_rd    = 1'b0;
        case (state)
            IDLE: begin
                // A write is always followed by a readback, so a coincident step needs no extra read.
                rb_flag_nxt = 1'b0;
                if (wr) begin
                    latch_wr  = 1'b1;
                    state_nxt = WR_PEND;
                end else if (step || rb_flag) begin
                    state_nxt = RD_PEND;
                end
            end
            WR_PEND: begin
                rb_flag_nxt = rb_flag | step;
                if (!bus.disp_req_i) begin
                    issue_wr  = 1'b1;
                    state_nxt = RD_PEND;
                end
            end
            RD_PEND: begin
                rb_flag_nxt = rb_flag | step;
                if (!bus.disp_req_i) begin
                    issue_rd  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ram_addr_o = cursor_o;
        tag_in         = NONE;
        if (bus.disp_req_i) begin
            bus.ram_addr_o = bus.disp_addr_i;
            tag_in         = DISP;
        end else if (issue_wr) begin
            bus.ram_addr_o = wr_addr;
        end else if (issue_rd) begin
            tag_in = HOST;
        end
    end

    // Reset is synchronous, so the write must be masked during the reset cycle itself.
    assign bus.ram_wren_o = issue_wr & ~rst_i;
    assign bus.ram_data_o = wr_data;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state      <= IDLE;
            rb_flag    <= 1'b0;
            cursor_o   <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cur_data_o <= '0;
        end else begin
            state   <= state_nxt;
            rb_flag <= rb_flag_nxt;
            if (latch_wr) begin
                wr_addr <= cursor_o;
                wr_data <= data_sw_i;
            end
            if (step)            cursor_o   <= cursor_step(cursor_o, addr_inc_dir_i);
            if (tag_out == HOST) cur_data_o <= bus.ram_q_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            for (int i = 0; i < RAM_LAT; i++) tag_q[i] <= NONE;
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < RAM_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_out          = tag_q[RAM_LAT-1];
    assign bus.disp_valid_o = (tag_out == DISP);
    assign bus.disp_data_o  = (tag_out == DISP) ? bus.ram_q_i : '0;

    always_comb begin
        host_in_flight = 1'b0;
        for (int i = 0; i < RAM_LAT; i++)
            if (tag_q[i] == HOST) host_in_flight = 1'b1;
    end

    assign busy_o = (state != IDLE) || host_in_flight;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            stall_cnt   <= '0;
            stall_err_o <= 1'b0;
        end else if (state == IDLE || issue_wr || issue_rd) begin
            stall_cnt <= '0;
        end else if (stall_cnt <= LIM) begin
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == LIM) stall_err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_screen_ram_sched.sv
// Bench for screen_ram_sched: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based model of the scheduling rules.
module tb_screen_ram_sched;
    localparam int CELLS       = 2000;
    localparam int RAM_LAT     = 1;
    localparam int STALL_LIMIT = 255;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        addr_inc_i, addr_inc_dir_i, wren_i;
    logic [7:0]  data_sw_i;
    logic [10:0] cursor_o;
    logic [7:0]  cur_data_o;
    logic        busy_o, stall_err_o;

    always #5 clk = ~clk;

    screen_ram_sched_if bus ();

    screen_ram_sched #(.RAM_LAT(RAM_LAT), .STALL_LIMIT(STALL_LIMIT)) dut (
        .clk(clk), .rst_i(rst_i), .bus(bus),
        .addr_inc_i(addr_inc_i), .addr_inc_dir_i(addr_inc_dir_i), .wren_i(wren_i),
        .data_sw_i(data_sw_i), .cursor_o(cursor_o), .cur_data_o(cur_data_o),
        .busy_o(busy_o), .stall_err_o(stall_err_o)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] init_val(input int i);
        if (i >= 100 && i < 110) return 8'(8'h80 + i - 100);
        return 8'(i * 37 + 11);
    endfunction

    // ---------------- screen RAM ----------------
    logic [7:0] ram [2048];
    logic [7:0] q_pipe [RAM_LAT];
    bit         ram_init = 1'b0;

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 2048; i++) ram[i] <= init_val(i);
            ram_init <= 1'b1;
        end else if (bus.ram_wren_o) begin
            ram[bus.ram_addr_o] <= bus.ram_data_o;
        end
        q_pipe[0] <= ram[bus.ram_addr_o];
        for (int k = 1; k < RAM_LAT; k++) q_pipe[k] <= q_pipe[k-1];
    end
    assign bus.ram_q_i = q_pipe[RAM_LAT-1];

    // ---------------- reference model ----------------
    typedef struct { bit is_wr; int addr; int data; } op_t;
    op_t opq[$];
    int  exp_mem [2048];
    int  m_cursor, m_cur_data, m_wrdata, m_cnt;
    bit  m_err, m_flag, model_live;
    bit  h_inc [3];
    bit  h_wr  [3];
    int  ring_kind [8];   // 0 none, 1 display, 2 host readback
    int  ring_data [8];
    int  cyc = 0;

    // 0: nothing, 1: display fetch, 2: host write, 3: host readback
    function automatic int issue_kind();
        if (bus.disp_req_i) return 1;
        if (opq.size() == 0) return 0;
        return opq[0].is_wr ? 2 : 3;
    endfunction

    initial begin : model
        int  k, slot, cur, exp_addr;
        bit  step, wr, idle, hbusy;
        for (int i = 0; i < 2048; i++) exp_mem[i] = int'(init_val(i));
        forever begin
            @(negedge clk);
            cur = cyc % 8;
            if (rst_i) begin
                check("wren_in_reset", 32'(bus.ram_wren_o), 32'd0);
                opq.delete();
                m_cursor = 0; m_cur_data = 0; m_wrdata = 0; m_cnt = 0;
                m_err = 0; m_flag = 0; model_live = 1;
                for (int i = 0; i < 3; i++) begin h_inc[i] = 0; h_wr[i] = 0; end
                for (int i = 0; i < 8; i++) ring_kind[i] = 0;
            end else if (model_live) begin
                k = issue_kind();
                exp_addr = (k == 1) ? int'(bus.disp_addr_i) : (k == 2) ? opq[0].addr : m_cursor;
                hbusy = (opq.size() != 0);
                for (int j = 0; j < RAM_LAT; j++) if (ring_kind[(cyc + j) % 8] == 2) hbusy = 1;
                check("ram_addr",   32'(bus.ram_addr_o),   32'(exp_addr));
                check("ram_wren",   32'(bus.ram_wren_o),   32'(k == 2));
                check("ram_data",   32'(bus.ram_data_o),   32'(m_wrdata));
                check("disp_valid", 32'(bus.disp_valid_o), 32'(ring_kind[cur] == 1));
                check("disp_data",  32'(bus.disp_data_o),  (ring_kind[cur] == 1) ? 32'(ring_data[cur]) : 32'd0);
                check("cursor",     32'(cursor_o),         32'(m_cursor));
                check("cur_data",   32'(cur_data_o),       32'(m_cur_data));
                check("busy",       32'(busy_o),           32'(hbusy));
                check("stall_err",  32'(stall_err_o),      32'(m_err));

                // advance the model by one clock
                step = h_inc[1] && !h_inc[2];
                wr   = h_wr[1] && !h_wr[2];
                idle = (opq.size() == 0);
                slot = (cyc + RAM_LAT) % 8;
                if (ring_kind[cur] == 2) m_cur_data = ring_data[cur];
                ring_kind[cur]  = 0;
                ring_kind[slot] = 0;
                if (k == 1) begin
                    ring_kind[slot] = 1; ring_data[slot] = exp_mem[bus.disp_addr_i];
                end else if (k == 3) begin
                    ring_kind[slot] = 2; ring_data[slot] = exp_mem[m_cursor];
                end
                if (k == 2) exp_mem[opq[0].addr] = opq[0].data;
                if (k >= 2) opq.delete(0);
                if (idle || k >= 2) m_cnt = 0;
                else begin
                    if (m_cnt <= STALL_LIMIT) m_cnt++;
                    if (m_cnt > STALL_LIMIT) m_err = 1;
                end
                if (idle) begin
                    if (wr) begin
                        m_wrdata = int'(data_sw_i);
                        opq.push_back('{1'b1, m_cursor, int'(data_sw_i)});
                        opq.push_back('{1'b0, 0, 0});
                    end else if (step || m_flag) begin
                        opq.push_back('{1'b0, 0, 0});
                    end
                    m_flag = 0;
                end else if (step) begin
                    m_flag = 1;
                end
                if (step) m_cursor = addr_inc_dir_i ? (m_cursor + 1) % CELLS : (m_cursor + CELLS - 1) % CELLS;
                h_inc[2] = h_inc[1]; h_inc[1] = h_inc[0]; h_inc[0] = addr_inc_i;
                h_wr[2]  = h_wr[1];  h_wr[1]  = h_wr[0];  h_wr[0]  = wren_i;
            end
            cyc++;
        end
    end

    // ---------------- stimulus + literal expectations ----------------
    int nw, wt, wa, wd, np;

    task automatic cyc1();
        @(posedge clk); #1;
    endtask

    task automatic press_inc(input logic dir);
        addr_inc_dir_i = dir;
        addr_inc_i     = 1'b1;
        repeat (2) cyc1();
        addr_inc_i = 1'b0;
        repeat (8) cyc1();
    endtask

    initial begin
        addr_inc_i = 0; addr_inc_dir_i = 1; wren_i = 0; data_sw_i = 0;
        bus.disp_req_i = 0; bus.disp_addr_i = 0;
        repeat (3) @(posedge clk);
        #1 rst_i = 0;
        repeat (2) cyc1();

        // write left pending behind display traffic, then reset
        bus.disp_req_i = 1; bus.disp_addr_i = 11'd7; data_sw_i = 8'hEE;
        wren_i = 1; repeat (2) cyc1(); wren_i = 0; repeat (4) cyc1();
        check("busy_before_rst", 32'(busy_o), 32'd1);
        rst_i = 1; repeat (2) cyc1(); rst_i = 0; bus.disp_req_i = 0;
        nw = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.ram_wren_o) nw++;
            cyc1();
        end
        check("rst_no_write",   32'(nw), 32'd0);
        check("rst_cursor",     32'(cursor_o), 32'd0);
        check("rst_cur_data",   32'(cur_data_o), 32'd0);
        check("rst_busy",       32'(busy_o), 32'd0);
        check("rst_stall_err",  32'(stall_err_o), 32'd0);
        check("rst_disp_valid", 32'(bus.disp_valid_o), 32'd0);
        check("rst_ram_addr",   32'(bus.ram_addr_o), 32'd0);

        // cursor wrap both ways
        press_inc(1'b0);
        check("wrap_down", 32'(cursor_o), 32'd1999);
        press_inc(1'b1);
        check("wrap_up", 32'(cursor_o), 32'd0);

        // write + readback at cell 5
        repeat (5) press_inc(1'b1);
        check("cursor_5", 32'(cursor_o), 32'd5);
        data_sw_i = 8'h41; nw = 0; wt = -1; wa = 0; wd = 0;
        for (int t = 0; t < 12; t++) begin
            wren_i = (t <= 1);
            @(negedge clk);
            if (bus.ram_wren_o) begin nw++; wt = t; wa = int'(bus.ram_addr_o); wd = int'(bus.ram_data_o); end
            if (t == 5 + RAM_LAT) check("readback_data", 32'(cur_data_o), 32'h41);
            cyc1();
        end
        check("wr_count", 32'(nw), 32'd1);
        check("wr_cycle", 32'(wt), 32'd3);
        check("wr_addr",  32'(wa), 32'd5);
        check("wr_data",  32'(wd), 32'h41);

        // display priority over a pending write, second write edge dropped
        nw = 0; np = 0; wt = -1;
        for (int t = 0; t < 25; t++) begin
            bus.disp_req_i  = (t >= 3 && t <= 12);
            bus.disp_addr_i = 11'(100 + t - 3);
            wren_i    = (t <= 1) || (t >= 5 && t <= 7);
            data_sw_i = (t >= 5) ? 8'h77 : 8'h5A;
            @(negedge clk);
            if (bus.disp_valid_o) begin
                np++;
                check("prio_disp_data", 32'(bus.disp_data_o), 32'h80 + 32'(t) - 32'd3 - 32'(RAM_LAT));
            end
            if (bus.ram_wren_o) begin nw++; wt = t; wa = int'(bus.ram_addr_o); wd = int'(bus.ram_data_o); end
            if (t >= 3 && t <= 14 + RAM_LAT) check("busy_pend", 32'(busy_o), 32'd1);
            if (t == 15 + RAM_LAT) check("prio_readback", 32'(cur_data_o), 32'h5A);
            cyc1();
        end
        check("prio_disp_count", 32'(np), 32'd10);
        check("prio_wr_count",   32'(nw), 32'd1);
        check("prio_wr_cycle",   32'(wt), 32'd13);
        check("prio_wr_addr",    32'(wa), 32'd5);
        check("prio_wr_data",    32'(wd), 32'h5A);

        // continuous display demand starves a pending write
        nw = 0; wt = -1; data_sw_i = 8'h99;
        for (int t = 0; t < 320; t++) begin
            bus.disp_req_i  = (t < 300);
            bus.disp_addr_i = 11'($urandom_range(0, CELLS - 1));
            wren_i = (t <= 1);
            @(negedge clk);
            if (bus.ram_wren_o) begin nw++; wt = t; end
            if (t == 258) check("stall_early", 32'(stall_err_o), 32'd0);
            if (t == 259) check("stall_set",   32'(stall_err_o), 32'd1);
            if (t == 302 + RAM_LAT) check("stall_readback", 32'(cur_data_o), 32'h99);
            cyc1();
        end
        check("stall_wr_count", 32'(nw), 32'd1);
        check("stall_wr_cycle", 32'(wt), 32'd300);
        check("stall_sticky",   32'(stall_err_o), 32'd1);

        // random traffic with a mid-run reset
        for (int t = 0; t < 4000; t++) begin
            bus.disp_req_i  = ($urandom_range(0, 99) < 55);
            bus.disp_addr_i = 11'($urandom_range(0, CELLS - 1));
            if ($urandom_range(0, 5) == 0) addr_inc_i = ~addr_inc_i;
            if ($urandom_range(0, 9) == 0) wren_i = ~wren_i;
            addr_inc_dir_i = 1'($urandom_range(0, 1));
            data_sw_i      = 8'($urandom);
            if (t == 2000) rst_i = 1;
            if (t == 2002) rst_i = 0;
            cyc1();
        end
        bus.disp_req_i = 0; addr_inc_i = 0; wren_i = 0;
        repeat (10) cyc1();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
